// File: rtl/scalar_mult_ctrl.sv
// Montgomery-ladder sequencer for Q = k*P on a shared extended-coordinate
// point-add unit. It owns the ladder registers R0/R1 and the bit counter and
// issues one add and one double for every scalar bit, MSB first. It never
// skips leading zeros, so the pulse count and the timing do not depend on k.
// Coordinates pass through unchanged. No field arithmetic happens here.
module scalar_mult_ctrl #(
  parameter int                  DATA_W  = 255,
  parameter int                  NBITS   = 255,
  parameter logic [DATA_W-1:0]   ONE_REP = 255'd1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [NBITS-1:0]  i_scalar,
  input  logic [DATA_W-1:0] i_px,
  input  logic [DATA_W-1:0] i_py,
  input  logic [DATA_W-1:0] i_pz,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_qx,
  output logic [DATA_W-1:0] o_qy,
  output logic [DATA_W-1:0] o_qz,
  output logic              o_pa_start,
  output logic [DATA_W-1:0] o_pa_x1,
  output logic [DATA_W-1:0] o_pa_y1,
  output logic [DATA_W-1:0] o_pa_z1,
  output logic [DATA_W-1:0] o_pa_x2,
  output logic [DATA_W-1:0] o_pa_y2,
  output logic [DATA_W-1:0] o_pa_z2,
  input  logic [DATA_W-1:0] i_pa_x3,
  input  logic [DATA_W-1:0] i_pa_y3,
  input  logic [DATA_W-1:0] i_pa_z3,
  input  logic              i_pa_finished
);

  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADD, S_WAIT_ADD, S_DBL, S_WAIT_DBL, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [NBITS-1:0]   k_r;
  logic [DATA_W-1:0]  px_r, py_r, pz_r;
  logic [DATA_W-1:0]  r0x, r0y, r0z, r1x, r1y, r1z;
  logic [DATA_W-1:0]  rbx, rby, rbz;
  logic               bit_b;

  // Current scalar bit and the ladder register it selects for doubling
  assign bit_b = k_r[idx];
  assign rbx   = bit_b ? r1x : r0x;
  assign rby   = bit_b ? r1y : r0y;
  assign rbz   = bit_b ? r1z : r0z;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; completions are only honoured in the two wait states
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_start) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_ADD;
      S_ADD:      state_nxt = S_WAIT_ADD;
      S_WAIT_ADD: if (i_pa_finished) state_nxt = S_DBL;
      S_DBL:      state_nxt = S_WAIT_DBL;
      S_WAIT_DBL: if (i_pa_finished) state_nxt = S_NEXT;
      S_NEXT:     state_nxt = (idx == '0) ? S_DONE : S_ADD;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Registered control outputs, decoded from the state being entered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pa_start <= 1'b0;
    end else begin
      o_busy     <= (state_nxt != S_IDLE);
      o_done     <= (state_nxt == S_DONE);
      o_pa_start <= (state_nxt == S_ADD) || (state_nxt == S_DBL);
    end
  end

  // Bit counter: starts at the MSB, counts down once per completed step
  always_ff @(posedge i_clk) begin
    if (i_rst)                                idx <= '0;
    else if (state == S_LOAD)                 idx <= IDX_W'(NBITS - 1);
    else if (state == S_NEXT && idx != '0)    idx <= idx - IDX_W'(1);
  end

  // Capture k and P only when a start is accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_r  <= '0;
      px_r <= '0;
      py_r <= '0;
      pz_r <= '0;
    end else if (state == S_IDLE && i_start) begin
      k_r  <= i_scalar;
      px_r <= i_px;
      py_r <= i_py;
      pz_r <= i_pz;
    end
  end

  // Ladder registers: add result goes to R[1-b], double result to R[b]
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {r0x, r0y, r0z} <= '0;
      {r1x, r1y, r1z} <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          {r0x, r0y, r0z} <= {{DATA_W{1'b0}}, ONE_REP, ONE_REP};
          {r1x, r1y, r1z} <= {px_r, py_r, pz_r};
        end
        S_WAIT_ADD: if (i_pa_finished) begin
          if (bit_b) {r0x, r0y, r0z} <= {i_pa_x3, i_pa_y3, i_pa_z3};
          else       {r1x, r1y, r1z} <= {i_pa_x3, i_pa_y3, i_pa_z3};
        end
        S_WAIT_DBL: if (i_pa_finished) begin
          if (bit_b) {r1x, r1y, r1z} <= {i_pa_x3, i_pa_y3, i_pa_z3};
          else       {r0x, r0y, r0z} <= {i_pa_x3, i_pa_y3, i_pa_z3};
        end
        default: ;
      endcase
    end
  end

  // Operands load as the add/double state is entered and then hold until the
  // next request. The first add bypasses R0/R1 because they load on that same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2} <= '0;
    end else if (state == S_LOAD) begin
      {o_pa_x1, o_pa_y1, o_pa_z1} <= {{DATA_W{1'b0}}, ONE_REP, ONE_REP};
      {o_pa_x2, o_pa_y2, o_pa_z2} <= {px_r, py_r, pz_r};
    end else if (state == S_NEXT && state_nxt == S_ADD) begin
      {o_pa_x1, o_pa_y1, o_pa_z1} <= {r0x, r0y, r0z};
      {o_pa_x2, o_pa_y2, o_pa_z2} <= {r1x, r1y, r1z};
    end else if (state == S_WAIT_ADD && i_pa_finished) begin
      {o_pa_x1, o_pa_y1, o_pa_z1} <= {rbx, rby, rbz};
      {o_pa_x2, o_pa_y2, o_pa_z2} <= {rbx, rby, rbz};
    end else if (state_nxt == S_IDLE) begin
      {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2} <= '0;
    end
  end

  // Result register: R0 is final when the ladder leaves its last step
  always_ff @(posedge i_clk) begin
    if (i_rst)                    {o_qx, o_qy, o_qz} <= '0;
    else if (state_nxt == S_DONE) {o_qx, o_qy, o_qz} <= {r0x, r0y, r0z};
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl. A behavioural point-add stub implements a simple
// abelian group on (x,y,z) with identity (0,1,1):
//   x3 = x1+x2, y3 = y1+y2-1, z3 = z1^z2^1 (all mod 2^255).
// For that group k*P has a closed form (x=k*px, y=k*(py-1)+1, z = k odd ? pz : 1),
// and the bench uses that closed form as its reference result.
module tb_scalar_mult_ctrl;
  localparam int NB = 255;
  localparam int W  = 255;
  typedef logic [W-1:0] fe_t;
  localparam fe_t ONE = 255'd1;

  logic          i_clk, i_rst, i_start;
  logic [NB-1:0] i_scalar;
  fe_t           i_px, i_py, i_pz;
  logic          o_busy, o_done, o_pa_start;
  fe_t           o_qx, o_qy, o_qz;
  fe_t           o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2;
  fe_t           i_pa_x3, i_pa_y3, i_pa_z3;
  logic          i_pa_finished;
  logic          stub_fin, spur;

  assign i_pa_finished = stub_fin | spur;

  scalar_mult_ctrl #(.DATA_W(W), .NBITS(NB), .ONE_REP(ONE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_scalar(i_scalar),
    .i_px(i_px), .i_py(i_py), .i_pz(i_pz),
    .o_busy(o_busy), .o_done(o_done), .o_qx(o_qx), .o_qy(o_qy), .o_qz(o_qz),
    .o_pa_start(o_pa_start),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1),
    .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2),
    .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3),
    .i_pa_finished(i_pa_finished)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Stub control and observation
  int  lat_mode  = 0;   // 0: fixed latency, 1: random 1..20 per call
  int  lat_fixed = 3;
  int  pulses    = 0;
  int  stab_err  = 0;
  bit  pending   = 0;
  int  cnt       = 0;
  fe_t cx1, cy1, cz1, cx2, cy2, cz2;

  function automatic fe_t rnd();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Point-add stub: sampled and driven on the falling edge
  initial begin
    stub_fin = 1'b0;
    i_pa_x3 = '0; i_pa_y3 = '0; i_pa_z3 = '0;
    forever begin
      @(negedge i_clk);
      stub_fin = 1'b0;
      i_pa_x3 = rnd(); i_pa_y3 = rnd(); i_pa_z3 = rnd();
      if (i_rst) begin
        pending = 0;
      end else begin
        if (o_pa_start && pending) stab_err++;
        if (pending) begin
          if ({o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2} !==
              {cx1, cy1, cz1, cx2, cy2, cz2}) stab_err++;
          cnt--;
          if (cnt == 0) begin
            stub_fin = 1'b1;
            i_pa_x3  = cx1 + cx2;
            i_pa_y3  = cy1 + cy2 - ONE;
            i_pa_z3  = cz1 ^ cz2 ^ ONE;
            pending  = 0;
          end
        end
        if (o_pa_start) begin
          pulses++;
          {cx1, cy1, cz1, cx2, cy2, cz2} =
            {o_pa_x1, o_pa_y1, o_pa_z1, o_pa_x2, o_pa_y2, o_pa_z2};
          cnt     = (lat_mode != 0) ? int'($urandom_range(20, 1)) : lat_fixed;
          pending = 1;
        end
      end
    end
  end

  task automatic check(input string tag, input fe_t obs, input fe_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form k*P in the stub group
  task automatic model(input logic [NB-1:0] k, input fe_t px, py, pz,
                       output fe_t qx, qy, qz);
    fe_t kk;
    kk = fe_t'(k);
    qx = kk * px;
    qy = kk * (py - ONE) + ONE;
    qz = k[0] ? pz : ONE;
  endtask

  task automatic start_op(input logic [NB-1:0] k, input fe_t px, py, pz);
    @(posedge i_clk); #1;
    pulses   = 0;
    stab_err = 0;
    i_scalar = k; i_px = px; i_py = py; i_pz = pz;
    i_start  = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
  endtask

  // Returns the cycle index of o_done counted from the start-high cycle
  task automatic wait_done(input bit noise, output int cyc);
    cyc = 1;
    while (!o_done && cyc < 20000) begin
      spur = 1'b0;
      if (noise) begin
        i_start  = 1'($urandom_range(1, 0));
        i_scalar = NB'(rnd());
        i_px     = rnd();
        if (o_pa_start) spur = 1'b1;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    spur    = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [NB-1:0] k,
                               input fe_t px, py, pz, input bit noise);
    fe_t ex, ey, ez;
    int  cyc;
    model(k, px, py, pz, ex, ey, ez);
    start_op(k, px, py, pz);
    wait_done(noise, cyc);
    check({tag, "_done"}, fe_t'(o_done), fe_t'(1));
    check({tag, "_busy_at_done"}, fe_t'(o_busy), fe_t'(1));
    check({tag, "_qx"}, o_qx, ex);
    check({tag, "_qy"}, o_qy, ey);
    check({tag, "_qz"}, o_qz, ez);
    check({tag, "_pulses"}, fe_t'(pulses), fe_t'(2 * NB));
    check({tag, "_operand_stability"}, fe_t'(stab_err), fe_t'(0));
    if (lat_mode == 0)
      check({tag, "_cycles"}, fe_t'(cyc), fe_t'(1 + NB * (2 * (lat_fixed + 1) + 1) + 1));
    @(posedge i_clk); #1;
    check({tag, "_busy_after"}, fe_t'(o_busy), fe_t'(0));
    check({tag, "_done_pulse"}, fe_t'(o_done), fe_t'(0));
    check({tag, "_ops_zero_idle"}, o_pa_x2 | o_pa_y1, fe_t'(0));
  endtask

  initial begin
    fe_t px, py, pz, hx, hy, hz;
    logic [NB-1:0] kbig;
    int n;
    i_rst = 1'b1; i_start = 1'b0; spur = 1'b0;
    i_scalar = '0; i_px = '0; i_py = '0; i_pz = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", fe_t'(o_busy), fe_t'(0));
    check("rst_done", fe_t'(o_done), fe_t'(0));
    check("rst_pa_start", fe_t'(o_pa_start), fe_t'(0));
    check("rst_q", o_qx | o_qy | o_qz, fe_t'(0));
    check("rst_ops", o_pa_x1 | o_pa_y1 | o_pa_z1 | o_pa_x2 | o_pa_y2 | o_pa_z2, fe_t'(0));
    i_rst = 1'b0;

    // Fixed latency 3
    lat_mode = 0; lat_fixed = 3;
    run_and_check("k0", '0, rnd(), rnd(), rnd(), 1'b0);
    px = rnd(); py = rnd(); pz = rnd();
    run_and_check("k1", NB'(1), px, py, pz, 1'b0);
    run_and_check("k2", NB'(2), rnd(), rnd(), rnd(), 1'b0);

    // Random latency per call
    lat_mode = 1;
    kbig = '0; kbig[254] = 1'b1; kbig = kbig + NB'(5);
    run_and_check("k2p254p5", kbig, rnd(), rnd(), rnd(), 1'b0);
    run_and_check("krand", NB'(rnd()), rnd(), rnd(), rnd(), 1'b0);

    // Start/scalar noise while busy, spurious completions on request cycles
    run_and_check("knoise", NB'(rnd()), rnd(), rnd(), rnd(), 1'b1);

    // Spurious completions while idle must not start anything or touch Q
    hx = o_qx; hy = o_qy; hz = o_qz;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      spur = 1'(i % 2 == 0);
      i_pa_x3 = rnd();
      @(posedge i_clk); #1;
    end
    spur = 1'b0;
    check("idle_spur_busy", fe_t'(o_busy), fe_t'(0));
    check("idle_spur_pulses", fe_t'(pulses), fe_t'(0));
    check("idle_spur_q", o_qx ^ hx | o_qy ^ hy | o_qz ^ hz, fe_t'(0));

    // Reset in the middle of an operation
    start_op(NB'(rnd()), rnd(), rnd(), rnd());
    n = 0;
    while (pulses < 100 && n < 5000) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("midrst_reached_step100", fe_t'(pulses >= 100), fe_t'(1));
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("midrst_busy", fe_t'(o_busy), fe_t'(0));
    check("midrst_pa_start", fe_t'(o_pa_start), fe_t'(0));
    check("midrst_done", fe_t'(o_done), fe_t'(0));
    check("midrst_q", o_qx | o_qy | o_qz, fe_t'(0));
    check("midrst_ops", o_pa_x1 | o_pa_y1 | o_pa_z1 | o_pa_x2 | o_pa_y2 | o_pa_z2, fe_t'(0));
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    run_and_check("after_rst", NB'(rnd()), rnd(), rnd(), rnd(), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
